// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the serial link: frame line levels,
// the default word width and the receiver state encoding.
package serial_link_pkg;

    // Default data bits per frame; the transmitter uses the same value.
    localparam int DEFAULT_WIDTH = 8;

    // Line levels that make up a frame.
    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    // Receiver states.
    // HUNT waits for an idle line, so a line stuck high is never taken
    // as a run of start bits.
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2,
        STOP = 2'd3
    } rx_state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for serial framing.
// It has a synchronous clear and a count enable, and is shared with the
// transmitter.
module serial_bit_counter
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count bits while enabled; clear takes priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_in_receiver.sv
// Serial receiver. It detects frames made of a start bit, WIDTH data bits
// sent MSB first and a stop bit.
// Each good word is presented with a one-cycle valid pulse.
// A bad stop bit raises a one-cycle error pulse.
// The receiver also counts good frames.
module serial_in_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serialIn,
    output logic [WIDTH-1:0]   dataOut,
    output logic               dataValid,
    output logic               frameErr,
    output logic [COUNT_W-1:0] frameCount
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;
    logic             stop_good;
    logic             stop_bad;

    // The counter is held at zero outside DATA.
    // As a result, every frame starts counting from bit 0.
    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state != DATA),
        .en    (state == DATA),
        .count (bit_cnt)
    );

    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign stop_good = (state == STOP) && (serialIn == STOP_BIT);
    assign stop_bad  = (state == STOP) && (serialIn != STOP_BIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A good stop bit returns to IDLE, so a start bit in the next cycle is
    // accepted.
    // A bad stop bit goes back to HUNT, which waits for the line to go idle.
    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (serialIn == IDLE_LEVEL) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (serialIn == START_BIT) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (last_bit) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                state_next = stop_good ? IDLE : HUNT;
            end
            default: state_next = HUNT;
        endcase
    end

    // Shift data bits in MSB first.
    // After WIDTH shifts, the first bit received sits in the top position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (state == DATA) begin
            shreg <= {shreg[WIDTH-2:0], serialIn};
        end
    end

    // Registered outputs, updated on the stop-bit sampling edge.
    // The valid and error pulses are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut    <= '0;
            dataValid  <= 1'b0;
            frameErr   <= 1'b0;
            frameCount <= '0;
        end else begin
            dataValid <= stop_good;
            frameErr  <= stop_bad;
            if (stop_good) begin
                dataOut    <= shreg;
                frameCount <= frameCount + 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_in_receiver.md
Name: serial_in_receiver

Overview:
- Receive end of the serial link driven by the serial-out shift register.
- Samples one bit per `clk` on `serialIn` and detects framed words: start bit, WIDTH data bits MSB-first, stop bit.
- Presents each good word on a parallel bus with a one-cycle valid pulse.
- Flags framing errors and counts good frames, for bench checking and for downstream logic.

Parameters:
- WIDTH, 8: data bits per frame (legal values 2..32).
- COUNT_W, 16: width of the good-frame counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- serialIn  input  1  serial line, same clock domain as the transmitter. Idle level 0.
- dataOut  output  WIDTH  last good received word. Held until the next good frame.
- dataValid  output  1  one-cycle pulse: dataOut has just been updated.
- frameErr  output  1  one-cycle pulse: stop bit was 1.
- frameCount  output  COUNT_W  number of good frames received, modulo 2^COUNT_W.

Behaviour:
- Reset (async, active-high): state=HUNT, shift register=0, bitCnt=0, dataOut=0, dataValid=0, frameErr=0, frameCount=0. Takes effect immediately, including mid-frame. A partial frame is discarded and never reported.
- Frame format on the line: 1 (start), d[WIDTH-1] … d[0] (MSB first), 0 (stop). One bit per clk cycle.
- States:
  - HUNT: wait for the line to be idle. If serialIn==0 -> IDLE, else stay. This prevents a line stuck high after reset or after an error from being taken as a stream of start bits.
  - IDLE: if serialIn==1 (start) -> DATA with bitCnt=0, else stay.
  - DATA: shreg <= {shreg[WIDTH-2:0], serialIn}, bitCnt++. On the edge sampling bitCnt==WIDTH-1 -> STOP.
  - STOP:
    - serialIn==0 (good): on this edge dataOut<=shreg, dataValid<=1, frameCount<=frameCount+1 (wraps to 0 silently), next state IDLE.
    - serialIn==1 (bad): frameErr<=1, dataOut/frameCount unchanged, next state HUNT.
- Outputs:
  - dataValid and frameErr are registered. Each is high exactly for the cycle following the stop-bit sampling edge, and low otherwise.
  - dataValid and frameErr are never both high.
- Latency: start bit sampled at edge N -> dataValid high after edge N+WIDTH+1.
- Back-to-back frames: the stop bit returns the FSM to IDLE, so a start bit in the very next cycle is accepted. Minimum frame period is WIDTH+2 cycles, with no gap required.
- Consecutive good frames produce dataValid pulses exactly WIDTH+2 cycles apart.
- The stop bit's 0 also serves as idle; no extra idle cycle is required after an error beyond the HUNT 0-detection.
- No backpressure: a consumer that misses the dataValid pulse loses the word (dataOut still holds it until overwritten).

Decomposition:
- Shared package `serial_link_pkg`:
  - state enum (HUNT, IDLE, DATA, STOP)
  - START_BIT=1, STOP_BIT=0, IDLE_LEVEL=0
  - default WIDTH=8, shared with the transmitter so both ends agree on the frame format.
- Sub-module: none required. The bit counter plus shifter are small enough to stay inline. An optional `serial_bit_counter` (clog2(WIDTH)-bit, sync clear, enable) may be split out if the transmitter reuses it.

Test Plan (WIDTH=8, COUNT_W=16 unless stated):
- Reset, then line 0 for 5 cycles, then frame 1,1010_0101,0 -> dataOut=8'hA5, dataValid high exactly 1 cycle, 10 cycles after the start edge; frameCount=1; frameErr never high.
- Two back-to-back frames, 8'h3C then 8'hFF, no gap -> two dataValid pulses 10 cycles apart; dataOut 8'h3C then 8'hFF; frameCount=2.
- Frame 8'h81 with stop bit 1 -> frameErr 1-cycle pulse, dataValid stays 0, dataOut keeps its previous value, frameCount unchanged. Line held 1 for 20 cycles -> no activity. Line to 0, then good frame 8'h55 -> received correctly.
- Line held 1 from reset release for 30 cycles -> stays in HUNT, no dataValid or frameErr pulses. Line to 0, then frame 8'h0F -> dataOut=8'h0F.
- Assert rst asynchronously mid-data (after 4 data bits of 8'hC3), release, then send a full 8'h5A -> no pulse for the partial frame; dataOut=8'h5A; frameCount=1.
- COUNT_W=4: send 17 good frames (values 0..16 mod 256) -> frameCount reads 15 after frame 15, 0 after frame 16, 1 after frame 17; each dataOut matches the value sent.
